// File: rtl/axi_rd_arbiter_if.sv
// AXI3 read-address / read-data channel bundle between the arbiter and the
// top-level AXI read pins.
//   master modport: drives AR fields, arvalid and rready; samples arready and R.
//   slave modport : the memory side of the same signals.
interface axi_rd_arbiter_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    output arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    input  arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI3 read channel between the instruction
// fetch port and the MEM-stage load port. One single-beat transaction is in
// flight at a time; responses are steered by the registered owner. A fetch
// cancelled by flush still completes on AXI but its data is discarded.
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   flush                  pipeline flush, cancels an in-flight fetch only
//   inst_req/addr          fetch request (held until inst_gnt)
//   inst_gnt               combinational accept pulse
//   inst_rvalid/rdata      registered fetch response
//   data_req/addr/size     load request (held until data_gnt)
//   data_gnt               combinational accept pulse
//   data_rvalid/rdata      registered load response
//   rd_err                 pulses with *_rvalid when rresp != 0
//   busy                   transaction in progress
//   axi                    AXI AR/R channel (master side)
module axi_rd_arbiter #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        flush,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [2:0]  data_size,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        rd_err,
  output logic        busy,
  axi_rd_arbiter_if.master axi
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  state_t state_q, state_d;
  owner_t owner_q, last_owner_q;
  logic   flush_q;

  logic   take_ar;
  logic   pick_data;
  logic   deliver;
  logic   flush_set;
  logic   beat_last;
  logic   inst_own;

  // rid carries no information with a single outstanding transaction
  logic   unused_rid;
  assign unused_rid = ^axi.rid;

  assign beat_last = axi.rvalid && axi.rlast;
  assign inst_own  = (owner_q == OWN_INST);

  // Fixed single-beat incrementing burst, normal access
  assign axi.arlen   = 4'd0;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, arbitration and grant pulses
  always_comb begin
    state_d   = state_q;
    take_ar   = 1'b0;
    pick_data = 1'b0;
    deliver   = 1'b0;
    flush_set = 1'b0;
    inst_gnt  = 1'b0;
    data_gnt  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (inst_req || data_req) begin
          take_ar   = 1'b1;
          // On a tie the port that did not own the last transaction wins
          pick_data = data_req && (!inst_req || (last_owner_q == OWN_INST));
          inst_gnt  = !pick_data;
          data_gnt  = pick_data;
          state_d   = ST_AR;
        end
      end
      ST_AR: begin
        if (inst_own && flush) begin
          flush_set = 1'b1;
        end
        if (axi.arready) begin
          state_d = (inst_own && (flush || flush_q)) ? ST_DROP : ST_R;
        end
      end
      ST_R: begin
        if (beat_last) begin
          state_d = ST_IDLE;
          // A flush coinciding with the fetch beat discards it
          deliver = !(inst_own && flush);
        end else if (inst_own && flush) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (beat_last) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // AR fields, ownership and flush latch
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      axi.araddr   <= '0;
      axi.arid     <= '0;
      axi.arsize   <= '0;
      owner_q      <= OWN_INST;
      last_owner_q <= OWN_INST;
      flush_q      <= 1'b0;
    end else begin
      if (take_ar) begin
        axi.araddr   <= pick_data ? data_addr : inst_addr;
        axi.arid     <= pick_data ? DATA_ID : INST_ID;
        axi.arsize   <= pick_data ? data_size : 3'b010;
        owner_q      <= pick_data ? OWN_DATA : OWN_INST;
        last_owner_q <= pick_data ? OWN_DATA : OWN_INST;
      end
      if (state_d == ST_IDLE) begin
        flush_q <= 1'b0;
      end else if (flush_set) begin
        flush_q <= 1'b1;
      end
    end
  end

  // Handshake and status outputs, registered from the next state
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      axi.arvalid <= (state_d == ST_AR);
      axi.rready  <= (state_d == ST_R) || (state_d == ST_DROP);
      busy        <= (state_d != ST_IDLE);
    end
  end

  // Response steering to the owning port
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      inst_rvalid <= 1'b0;
      data_rvalid <= 1'b0;
      rd_err      <= 1'b0;
      inst_rdata  <= '0;
      data_rdata  <= '0;
    end else begin
      inst_rvalid <= deliver && inst_own;
      data_rvalid <= deliver && !inst_own;
      rd_err      <= deliver && (axi.rresp != 2'b00);
      if (deliver && inst_own) begin
        inst_rdata <= DW'(axi.rdata);
      end
      if (deliver && !inst_own) begin
        data_rdata <= DW'(axi.rdata);
      end
    end
  end

  // Address width is fixed by the AXI pins
  if (AW != 32) begin : g_aw_check
    $error("axi_rd_arbiter supports 32-bit addresses only");
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed and randomized checks of axi_rd_arbiter against a transaction-level
// model: round-robin winner, AR fields, response phase and flush cancellation.
module tb_axi_rd_arbiter;

  logic        aclk;
  logic        aresetn;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [31:0] data_addr;
  logic [2:0]  data_size;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        rd_err;
  logic        busy;

  axi_rd_arbiter_if bus ();

  axi_rd_arbiter dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .flush       (flush),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_gnt    (inst_gnt),
    .inst_rvalid (inst_rvalid),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_addr   (data_addr),
    .data_size   (data_size),
    .data_gnt    (data_gnt),
    .data_rvalid (data_rvalid),
    .data_rdata  (data_rdata),
    .rd_err      (rd_err),
    .busy        (busy),
    .axi         (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;
  // Model state: 1 when the data port owned the most recent transaction
  bit model_last_data = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge aclk);
  endtask

  // One complete transaction. Cycle k=0 is the IDLE grant cycle, arready
  // arrives at k=1+ar_dly, the last beat at kb, the response is seen at kb+1.
  task automatic run_txn(input string t, input bit ireq, input bit dreq,
                         input logic [31:0] iaddr, input logic [31:0] daddr,
                         input logic [2:0] dsize, input int ar_dly, input int r_dly,
                         input bit nolast, input logic [31:0] rd,
                         input logic [1:0] rr, input int flush_at);
    bit win_data;
    bit drop;
    int kar;
    int kb;
    logic [31:0] exp_addr;
    logic [31:0] exp_id;
    logic [31:0] exp_size;
    win_data = dreq && (!ireq || !model_last_data);
    model_last_data = win_data;
    kar = 1 + ar_dly;
    kb  = kar + 1 + r_dly + (nolast ? 1 : 0);
    // Flush cancels a fetch anywhere between the cycle after grant and the beat
    drop = !win_data && (flush_at >= 1) && (flush_at <= kb);
    exp_addr = win_data ? daddr : iaddr;
    exp_id   = win_data ? 32'd1 : 32'd0;
    exp_size = win_data ? 32'(dsize) : 32'd2;
    for (int k = 0; k <= kb + 1; k++) begin
      next_cyc();
      inst_req     = (k == 0) ? ireq : 1'b0;
      data_req     = (k == 0) ? dreq : 1'b0;
      inst_addr    = iaddr;
      data_addr    = daddr;
      data_size    = dsize;
      flush        = (k == flush_at);
      bus.arready  = (k == kar);
      bus.rvalid   = (k == kb) || (nolast && (k == kb - 1));
      bus.rlast    = (k == kb);
      bus.rdata    = (k == kb) ? rd : $urandom();
      bus.rresp    = (k == kb) ? rr : 2'b11;
      bus.rid      = 4'($urandom_range(0, 15));
      at_sample();
      if (k == 0) begin
        chk({t, ":inst_gnt"}, 32'(inst_gnt), 32'(!win_data));
        chk({t, ":data_gnt"}, 32'(data_gnt), 32'(win_data));
        chk({t, ":idle_busy"}, 32'(busy), 32'd0);
        chk({t, ":idle_rv"}, 32'({inst_rvalid, data_rvalid, rd_err}), 32'd0);
        chk({t, ":idle_arvalid"}, 32'(bus.arvalid), 32'd0);
      end else if (k <= kar) begin
        chk({t, ":arvalid"}, 32'(bus.arvalid), 32'd1);
        chk({t, ":araddr"}, bus.araddr, exp_addr);
        chk({t, ":arid"}, 32'(bus.arid), exp_id);
        chk({t, ":arsize"}, 32'(bus.arsize), exp_size);
        chk({t, ":ar_rready"}, 32'(bus.rready), 32'd0);
        chk({t, ":ar_busy"}, 32'(busy), 32'd1);
        chk({t, ":no_gnt"}, 32'({inst_gnt, data_gnt}), 32'd0);
      end else if (k <= kb) begin
        chk({t, ":rready"}, 32'(bus.rready), 32'd1);
        chk({t, ":r_arvalid"}, 32'(bus.arvalid), 32'd0);
        chk({t, ":r_busy"}, 32'(busy), 32'd1);
        chk({t, ":r_rv"}, 32'({inst_rvalid, data_rvalid}), 32'd0);
      end else begin
        chk({t, ":inst_rvalid"}, 32'(inst_rvalid), 32'(!win_data && !drop));
        chk({t, ":data_rvalid"}, 32'(data_rvalid), 32'(win_data));
        chk({t, ":rd_err"}, 32'(rd_err), 32'(!drop && (rr != 2'b00)));
        chk({t, ":end_busy"}, 32'(busy), 32'd0);
        chk({t, ":end_rready"}, 32'(bus.rready), 32'd0);
        if (win_data) chk({t, ":data_rdata"}, data_rdata, rd);
        else if (!drop) chk({t, ":inst_rdata"}, inst_rdata, rd);
      end
    end
    flush = 1'b0;
  endtask

  task automatic chk_all_zero(input string t);
    chk({t, ":arvalid"}, 32'(bus.arvalid), 32'd0);
    chk({t, ":rready"}, 32'(bus.rready), 32'd0);
    chk({t, ":gnts"}, 32'({inst_gnt, data_gnt}), 32'd0);
    chk({t, ":rvalids"}, 32'({inst_rvalid, data_rvalid, rd_err}), 32'd0);
    chk({t, ":busy"}, 32'(busy), 32'd0);
    chk({t, ":araddr"}, bus.araddr, 32'd0);
    chk({t, ":arid"}, 32'(bus.arid), 32'd0);
    chk({t, ":arsize"}, 32'(bus.arsize), 32'd0);
    chk({t, ":inst_rdata"}, inst_rdata, 32'd0);
    chk({t, ":data_rdata"}, data_rdata, 32'd0);
  endtask

  initial begin
    int ar;
    int r;
    int nl;
    int kb;
    int sel;
    aresetn     = 1'b0;
    flush       = 1'b0;
    inst_req    = 1'b0;
    inst_addr   = '0;
    data_req    = 1'b0;
    data_addr   = '0;
    data_size   = '0;
    bus.arready = 1'b0;
    bus.rid     = '0;
    bus.rdata   = '0;
    bus.rresp   = '0;
    bus.rlast   = 1'b0;
    bus.rvalid  = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    chk_all_zero("reset");
    chk("const_arlen", 32'(bus.arlen), 32'd0);
    chk("const_arburst", 32'(bus.arburst), 32'd1);
    chk("const_misc", 32'({bus.arlock, bus.arcache, bus.arprot}), 32'd0);
    aresetn = 1'b1;
    model_last_data = 1'b0;

    // Single fetch, arready@1, beat@3
    run_txn("fetch", 1, 0, 32'hBFC00000, 32'h0, 3'd0, 0, 1, 0, 32'h3C1D0001, 2'b00, -1);
    // Ties from reset: data first, then alternating
    for (int i = 0; i < 5; i++)
      run_txn("tie", 1, 1, 32'hBFC00010 + 32'(i * 4), 32'h80001000 + 32'(i * 4),
              3'd2, i % 2, 0, 0, $urandom(), 2'b00, -1);
    // Byte load, rdata passed through unchanged
    run_txn("byte", 0, 1, 32'h0, 32'h80000003, 3'd0, 0, 0, 0, 32'hA5A5_5A5A, 2'b00, -1);
    // Flush during AR with arready delayed 3 cycles
    run_txn("flush_ar", 1, 0, 32'hBFC00100, 32'h0, 3'd0, 3, 0, 0, 32'h1111_2222, 2'b00, 1);
    // Flush on the arready cycle
    run_txn("flush_ardy", 1, 0, 32'hBFC00104, 32'h0, 3'd0, 2, 1, 0, 32'h3333_4444, 2'b00, 3);
    // Flush coincident with the fetch beat (kar=1, kb=4)
    run_txn("flush_beat", 1, 0, 32'hBFC00200, 32'h0, 3'd0, 0, 2, 0, 32'hDEAD_BEEF, 2'b00, 4);
    // Same flush during a load has no effect
    run_txn("flush_load", 0, 1, 32'h0, 32'h80000200, 3'd1, 0, 2, 0, 32'hCAFE_F00D, 2'b00, 4);
    // Flush in R before the beat, with a non-last beat ahead of it
    run_txn("flush_r", 1, 0, 32'hBFC00300, 32'h0, 3'd0, 1, 2, 1, 32'h5555_6666, 2'b00, 4);
    // Flush in the grant cycle is ignored, fetch delivered
    run_txn("flush_gnt", 1, 0, 32'hBFC00400, 32'h0, 3'd0, 0, 0, 0, 32'h7777_8888, 2'b00, 0);
    // Error response on a load, then on a dropped fetch
    run_txn("err_load", 0, 1, 32'h0, 32'h80000400, 3'd2, 1, 1, 0, 32'h0BAD_0BAD, 2'b10, -1);
    run_txn("err_drop", 1, 0, 32'hBFC00500, 32'h0, 3'd0, 0, 1, 0, 32'h0BAD_0BAD, 2'b10, 2);

    // Randomized transactions
    for (int i = 0; i < 60; i++) begin
      ar  = $urandom_range(0, 3);
      r   = $urandom_range(0, 3);
      nl  = $urandom_range(0, 1);
      kb  = 2 + ar + r + nl;
      sel = $urandom_range(1, 3);
      run_txn($sformatf("rnd%0d", i), sel[0], sel[1], $urandom(), $urandom(),
              3'($urandom_range(0, 2)), ar, r, nl[0], $urandom(),
              2'($urandom_range(0, 3)), $urandom_range(0, kb + 2) - 1);
    end

    // Asynchronous reset while in R
    next_cyc();
    inst_req  = 1'b1;
    inst_addr = 32'hBFC00600;
    at_sample();
    chk("rst_gnt", 32'(inst_gnt), 32'(1'b1));
    next_cyc();
    inst_req    = 1'b0;
    bus.arready = 1'b1;
    at_sample();
    next_cyc();
    bus.arready = 1'b0;
    at_sample();
    chk("rst_pre_rready", 32'(bus.rready), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    next_cyc();
    aresetn = 1'b1;
    model_last_data = 1'b0;
    // Reset restores the tie-break so data wins again
    run_txn("post_rst_tie", 1, 1, 32'hBFC00700, 32'h80000700, 3'd2, 0, 0, 0,
            32'h1234_5678, 2'b00, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
